// File: rtl/writeback_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : writeback_buffer_pkg
// Purpose  : Shared CPU definitions for the writeback buffer: default data,
//            register-address and queue-depth sizes, the queued entry record
//            {wa, wd} and a helper for the occupancy counter width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package writeback_buffer_pkg;

  localparam int WB_WIDTH   = 32;
  localparam int WB_REGBITS = 5;
  localparam int WB_DEPTH   = 4;

  // One pending register-file write at the default sizes.
  typedef struct packed {
    logic [WB_REGBITS-1:0] wa;
    logic [WB_WIDTH-1:0]   wd;
  } wb_entry_t;

  // The counter must represent DEPTH itself, hence one bit beyond the pointer.
  function automatic int wb_count_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_buffer_wb_match.sv
`default_nettype none
// ============================================================================
// Module   : wb_match
// Purpose  : Combinational youngest-match lookup over the queued entries for
//            one decode read port.
// Ports    : valid  - per-slot occupancy, slot 0 is the oldest entry
//            wa, wd - queued destination / data, in the same age order
//            ra     - read address to look up (0 never matches)
//            hit    - some occupied entry writes ra
//            data   - wd of the youngest matching entry, 0 without a hit
// Revision : 1.0 - initial release
// ============================================================================
module wb_match #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5,
  parameter int DEPTH   = 4
) (
  input  logic [DEPTH-1:0]   valid,
  input  logic [REGBITS-1:0] wa [DEPTH],
  input  logic [WIDTH-1:0]   wd [DEPTH],
  input  logic [REGBITS-1:0] ra,
  output logic               hit,
  output logic [WIDTH-1:0]   data
);

  // Scanning oldest to youngest lets later matches overwrite earlier ones,
  // so the youngest write to the register wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (ra != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && (wa[i] == ra)) begin
          hit  = 1'b1;
          data = wd[i];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : writeback_buffer
// Purpose  : In-order queue of (wa, wd) results draining onto the register
//            file write port, with forwarding of pending writes to two
//            decode read ports.
// Ports    : clk, reset_n             - clock, async active-low reset
//            in_valid/in_ready        - producer handshake
//            in_wa, in_wd             - incoming destination / result
//            hold                     - write port unavailable this cycle
//            regwrite, wa, wd         - register-file write port
//            ra1, ra2                 - decode read addresses
//            fwd1_hit/data, fwd2_*    - forwarding results per read port
//            count, empty             - occupancy
// Revision : 1.0 - initial release
// ============================================================================
module writeback_buffer
  import writeback_buffer_pkg::*;
#(
  parameter int WIDTH   = WB_WIDTH,
  parameter int REGBITS = WB_REGBITS,
  parameter int DEPTH   = WB_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REGBITS-1:0]       in_wa,
  input  logic [WIDTH-1:0]         in_wd,
  input  logic                     hold,
  output logic                     regwrite,
  output logic [REGBITS-1:0]       wa,
  output logic [WIDTH-1:0]         wd,
  input  logic [REGBITS-1:0]       ra1,
  input  logic [REGBITS-1:0]       ra2,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output logic [WIDTH-1:0]         fwd1_data,
  output logic [WIDTH-1:0]         fwd2_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = wb_count_bits(DEPTH);

  logic [REGBITS-1:0] mem_wa [DEPTH];
  logic [WIDTH-1:0]   mem_wd [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;

  logic               push;
  logic               pop;

  // Entries re-ordered so slot 0 is the head (oldest).
  logic [DEPTH-1:0]   ord_valid;
  logic [REGBITS-1:0] ord_wa [DEPTH];
  logic [WIDTH-1:0]   ord_wd [DEPTH];

  // in_ready depends on registered occupancy only: a pop this cycle does not
  // open a slot until the next cycle.
  assign in_ready = (count < CW'(DEPTH));
  assign empty    = (count == '0);
  // Writes to r0 complete the handshake but are dropped.
  assign push     = in_valid && in_ready && (in_wa != '0);
  assign regwrite = !empty && !hold;
  assign pop      = regwrite;

  assign wa = empty ? '0 : mem_wa[rd_ptr];
  assign wd = empty ? '0 : mem_wd[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is qualified by occupancy, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_wa[wr_ptr] <= in_wa;
      mem_wd[wr_ptr] <= in_wd;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_order
    assign ord_valid[i] = (CW'(i) < count);
    assign ord_wa[i]    = mem_wa[rd_ptr + PW'(i)];
    assign ord_wd[i]    = mem_wd[rd_ptr + PW'(i)];
  end

  wb_match #(.WIDTH(WIDTH), .REGBITS(REGBITS), .DEPTH(DEPTH)) u_match1 (
    .valid (ord_valid),
    .wa    (ord_wa),
    .wd    (ord_wd),
    .ra    (ra1),
    .hit   (fwd1_hit),
    .data  (fwd1_data)
  );

  wb_match #(.WIDTH(WIDTH), .REGBITS(REGBITS), .DEPTH(DEPTH)) u_match2 (
    .valid (ord_valid),
    .wa    (ord_wa),
    .wd    (ord_wd),
    .ra    (ra2),
    .hit   (fwd2_hit),
    .data  (fwd2_data)
  );

endmodule
`default_nettype wire
